// File: rtl/rca_nibble_sequencer_pkg.sv
// Shared types and constants for the nibble-serial ripple-carry adder.
package rca_nibble_sequencer_pkg;

   // Width of the shared ripple-carry slice
   localparam int unsigned NIB_W = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Nibble index width; a single-step adder still needs a 1-bit index
   function automatic int unsigned idx_width(input int unsigned nib);
      return (nib > 1) ? int'($clog2(nib)) : 1;
   endfunction

endpackage

// File: rtl/rca_nibble_sequencer_slice.sv
// Purely combinational 4-bit ripple-carry slice built from full adders.
module rca_slice_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[4];

endmodule

// File: rtl/rca_nibble_sequencer.sv
// Multi-cycle adder: sums WIDTH-bit operands one nibble per clock through a
// single shared 4-bit ripple-carry slice, LSB nibble first, carry held in a flop.
// WIDTH must be a multiple of 4 and at least 4.
module rca_nibble_sequencer
   import rca_nibble_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic             Cout
);

   localparam int unsigned NIB = WIDTH / NIB_W;
   localparam int unsigned IW  = idx_width(NIB);
   localparam logic [IW-1:0] LastIdx = IW'(NIB - 1);

   state_e           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;

   logic [NIB_W-1:0] a_nib, b_nib, s_nib;
   logic             co_nib;
   int unsigned      base;

   // Select the current nibble of each operand for the shared slice
   always_comb begin
      base  = NIB_W * 32'(idx_q);
      a_nib = a_q[base +: NIB_W];
      b_nib = b_q[base +: NIB_W];
   end

   rca_slice_4 u_slice (
      .a  (a_nib),
      .b  (b_nib),
      .ci (carry_q),
      .s  (s_nib),
      .co (co_nib)
   );

   // Next-state and datapath updates for the IDLE/RUN/DONE sequence
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      q_d     = q_q;
      carry_d = carry_q;
      cout_d  = cout_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               a_d     = A;
               b_d     = B;
               carry_d = Cin;
               idx_d   = '0;
               q_d     = '0;
            end
         end
         StRun: begin
            q_d[base +: NIB_W] = s_nib;
            carry_d            = co_nib;
            // Index saturates on the last nibble instead of wrapping
            if (idx_q == LastIdx) begin
               state_d = StDone;
               cout_d  = co_nib;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register with synchronous reset; reset abandons any operation
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         q_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         q_q     <= q_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q == StRun);
   assign done = (state_q == StDone);
   assign Q    = q_q;
   assign Cout = cout_q;

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Bench for the nibble-serial adder: directed cases plus random vectors on a
// 16-bit and a 4-bit instance, checked against plain A+B+Cin arithmetic.
module tb_rca_nibble_sequencer;

   logic clk = 1'b0;
   logic reset;

   logic        start16, cin16, busy16, done16, cout16;
   logic [15:0] a16, b16, q16;
   logic        start4, cin4, busy4, done4, cout4;
   logic [3:0]  a4, b4, q4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rca_nibble_sequencer #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .start (start16),
      .A     (a16),
      .B     (b16),
      .Cin   (cin16),
      .busy  (busy16),
      .done  (done16),
      .Q     (q16),
      .Cout  (cout16)
   );

   rca_nibble_sequencer #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .start (start4),
      .A     (a4),
      .B     (b4),
      .Cin   (cin4),
      .busy  (busy4),
      .done  (done4),
      .Q     (q4),
      .Cout  (cout4)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Run one 16-bit op: busy for 4 cycles, then a single done cycle with the sum
   task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic cin);
      logic [16:0] exp;
      exp = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      start16 = 1'b1; a16 = a; b16 = b; cin16 = cin;
      @(negedge clk);
      start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      for (int c = 1; c <= 4; c++) begin
         check_eq("hs16_run", {busy16, done16}, 2'b10);
         @(negedge clk);
      end
      check_eq("hs16_done", {busy16, done16}, 2'b01);
      check_eq("q16", q16, exp[15:0]);
      check_eq("cout16", cout16, exp[16]);
      @(negedge clk);
      check_eq("hs16_idle", {busy16, done16}, 2'b00);
      check_eq("q16_hold", q16, exp[15:0]);
   endtask

   // Run one 4-bit op: one busy cycle, then done
   task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic cin);
      logic [4:0] exp;
      exp = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      start4 = 1'b1; a4 = a; b4 = b; cin4 = cin;
      @(negedge clk);
      start4 = 1'b0;
      a4 = 4'($urandom);
      check_eq("hs4_run", {busy4, done4}, 2'b10);
      @(negedge clk);
      check_eq("hs4_done", {busy4, done4}, 2'b01);
      check_eq("q4", q4, exp[3:0]);
      check_eq("cout4", cout4, exp[4]);
      @(negedge clk);
      check_eq("hs4_idle", {busy4, done4}, 2'b00);
   endtask

   initial begin
      logic [16:0] exp;
      reset = 1'b1;
      start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
      start4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst16", {busy16, done16, cout16, q16}, '0);
      check_eq("rst4", {busy4, done4, cout4, q4}, '0);
      reset = 1'b0;
      @(negedge clk);

      run_op16(16'h1234, 16'h4321, 1'b0);
      run_op16(16'hFFFF, 16'h0001, 1'b0);
      run_op16(16'h8000, 16'h8000, 1'b1);

      // start held high; operands wander during the op
      exp = 17'h0A5A5 + 17'h01111;
      start16 = 1'b1; a16 = 16'hA5A5; b16 = 16'h1111; cin16 = 1'b0;
      @(negedge clk);
      for (int c = 1; c <= 4; c++) begin
         a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'b1;
         check_eq("held_run", {busy16, done16}, 2'b10);
         @(negedge clk);
      end
      check_eq("held_done", {busy16, done16}, 2'b01);
      check_eq("held_q", q16, exp[15:0]);
      check_eq("held_cout", cout16, exp[16]);
      a16 = 16'h0F0F; b16 = 16'hF0F1; cin16 = 1'b0;
      @(negedge clk);
      check_eq("held_idle", {busy16, done16}, 2'b00);
      run_op16(16'hFFFF, 16'h0002, 1'b1);

      // reset during the second RUN cycle
      start16 = 1'b1; a16 = 16'h00FF; b16 = 16'h0001; cin16 = 1'b0;
      @(negedge clk);
      start16 = 1'b0;
      @(negedge clk);
      check_eq("pre_rst_busy", busy16, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("mid_rst", {busy16, done16, cout16, q16}, '0);
      for (int c = 0; c < 6; c++) begin
         check_eq("no_done", done16, 1'b0);
         @(negedge clk);
      end
      run_op16(16'h00FF, 16'h0001, 1'b0);

      run_op4(4'hF, 4'hF, 1'b1);
      for (int i = 0; i < 50; i++)
         run_op4(4'($urandom), 4'($urandom), 1'($urandom));

      for (int i = 0; i < 1000; i++)
         run_op16(16'($urandom), 16'($urandom), 1'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
